// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational; EX-stage updates land on the next rising edge.
module btb_predictor #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic [31:0] pred_target,
  output logic [1:0]  btb_flag,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_uncond
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lookupIdx;
  logic [TAG_BITS-1:0]   lookupTag;
  logic                  lookupHit;
  logic                  predTaken;

  logic [INDEX_BITS-1:0] updIdx;
  logic [TAG_BITS-1:0]   updTag;
  logic                  updHit;

  logic                  wrEn;
  logic                  wrValid_d;
  logic [TAG_BITS-1:0]   wrTag_d;
  logic [31:0]           wrTarget_d;
  logic [1:0]            wrCtr_d;

  // The two low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  assign lookupIdx = if_pc[INDEX_BITS+1:2];
  assign lookupTag = if_pc[31:INDEX_BITS+2];
  assign lookupHit = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
  assign predTaken = lookupHit && ctr_q[lookupIdx][1];

  assign btb_flag    = {lookupHit, predTaken};
  assign pred_target = predTaken ? target_q[lookupIdx] : (if_pc + 32'd4);

  assign updIdx = upd_pc[INDEX_BITS+1:2];
  assign updTag = upd_pc[31:INDEX_BITS+2];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  // Next contents of the single entry addressed by the update port.
  always_comb begin
    wrEn       = 1'b0;
    wrValid_d  = valid_q[updIdx];
    wrTag_d    = tag_q[updIdx];
    wrTarget_d = target_q[updIdx];
    wrCtr_d    = ctr_q[updIdx];
    if (upd_valid) begin
      if (updHit) begin
        wrEn = 1'b1;
        if (upd_taken) begin
          wrCtr_d    = (ctr_q[updIdx] == 2'b11) ? 2'b11 : ctr_q[updIdx] + 2'b01;
          wrTarget_d = upd_target;
        end else begin
          wrCtr_d = (ctr_q[updIdx] == 2'b00) ? 2'b00 : ctr_q[updIdx] - 2'b01;
        end
      end else if (upd_taken) begin
        wrEn       = 1'b1;
        wrValid_d  = 1'b1;
        wrTag_d    = updTag;
        wrTarget_d = upd_target;
        wrCtr_d    = upd_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  // Tags and targets are left alone on reset; clearing valid is enough to hide them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wrEn) begin
      valid_q[updIdx]  <= wrValid_d;
      tag_q[updIdx]    <= wrTag_d;
      target_q[updIdx] <= wrTarget_d;
      ctr_q[updIdx]    <= wrCtr_d;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: a reference table model feeds a
// scoreboard queue of expected lookup results, compared after each drive.
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] pred_target;
  logic [1:0]  btb_flag;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_uncond;

  btb_predictor #(.INDEX_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .pred_target (pred_target),
    .btb_flag    (btb_flag),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .upd_uncond  (upd_uncond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  flag;
    logic [31:0] target;
  } expect_t;

  expect_t expectQ[$];

  logic        mValid  [16];
  logic [25:0] mTag    [16];
  logic [31:0] mTarget [16];
  logic [1:0]  mCtr    [16];

  int checkCount;
  int errorCount;

  logic [1:0]  lastFlag;
  logic [31:0] lastTarget;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic expect_t modelLookup(input logic [31:0] pc);
    expect_t e;
    logic hit;
    logic taken;
    hit      = mValid[pc[5:2]] && (mTag[pc[5:2]] == pc[31:6]);
    taken    = hit && mCtr[pc[5:2]][1];
    e.flag   = {hit, taken};
    e.target = taken ? mTarget[pc[5:2]] : pc + 32'd4;
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 2'b01;
    end
  endtask

  task automatic modelUpdate(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic uncond);
    logic [3:0] idx;
    idx = pc[5:2];
    if (mValid[idx] && mTag[idx] == pc[31:6]) begin
      if (taken) begin
        if (mCtr[idx] != 2'b11) mCtr[idx] = mCtr[idx] + 2'b01;
        mTarget[idx] = tgt;
      end else if (mCtr[idx] != 2'b00) begin
        mCtr[idx] = mCtr[idx] - 2'b01;
      end
    end else if (taken) begin
      mValid[idx]  = 1'b1;
      mTag[idx]    = pc[31:6];
      mTarget[idx] = tgt;
      mCtr[idx]    = uncond ? 2'b11 : 2'b10;
    end
  endtask

  // One cycle: drive, score the combinational lookup, then advance the model.
  task automatic applyStimulus(input logic r, input logic [31:0] pc,
                               input logic uv, input logic [31:0] upc,
                               input logic [31:0] utgt, input logic ut,
                               input logic uu);
    expect_t e;
    @(negedge clk);
    rst        = r;
    if_pc      = pc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_target = utgt;
    upd_taken  = ut;
    upd_uncond = uu;
    expectQ.push_back(modelLookup(pc));
    #1;
    e = expectQ.pop_front();
    checkOutput("flag", {30'd0, btb_flag}, {30'd0, e.flag});
    checkOutput("target", pred_target, e.target);
    lastFlag   = btb_flag;
    lastTarget = pred_target;
    if (r) modelReset();
    else if (uv) modelUpdate(upc, utgt, ut, uu);
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(1'b0, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] upc,
                        input logic [31:0] tgt, input logic t, input logic u);
    applyStimulus(1'b0, pc, 1'b1, upc, tgt, t, u);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    if_pc      = 32'h100;
    upd_valid  = 1'b0;
    upd_pc     = 32'd0;
    upd_target = 32'd0;
    upd_taken  = 1'b0;
    upd_uncond = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);

    applyStimulus(1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst_flag", {30'd0, lastFlag}, 32'd0);
    checkOutput("rst_target", lastTarget, 32'h104);
    lookup(32'h100);
    checkOutput("post_rst_flag", {30'd0, lastFlag}, 32'd0);

    update(32'h100, 32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100);
    checkOutput("alloc_flag", {30'd0, lastFlag}, 32'd3);
    checkOutput("alloc_target", lastTarget, 32'h200);

    update(32'h100, 32'h100, 32'h200, 1'b0, 1'b0);
    update(32'h100, 32'h100, 32'h200, 1'b0, 1'b0);
    lookup(32'h100);
    checkOutput("ctr00_flag", {30'd0, lastFlag}, 32'd2);
    checkOutput("ctr00_target", lastTarget, 32'h104);
    update(32'h100, 32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100);
    checkOutput("ctr01_flag", {30'd0, lastFlag}, 32'd2);
    update(32'h100, 32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100);
    checkOutput("ctr10_flag", {30'd0, lastFlag}, 32'd3);

    update(32'h0, 32'h140, 32'h300, 1'b1, 1'b0);
    lookup(32'h100);
    checkOutput("evict_old_flag", {30'd0, lastFlag}, 32'd0);
    lookup(32'h140);
    checkOutput("evict_new_flag", {30'd0, lastFlag}, 32'd3);
    checkOutput("evict_new_target", lastTarget, 32'h300);

    update(32'h180, 32'h180, 32'h500, 1'b1, 1'b0);
    checkOutput("same_cycle_flag", {30'd0, lastFlag}, 32'd0);
    lookup(32'h180);
    checkOutput("next_cycle_flag", {30'd0, lastFlag}, 32'd3);

    update(32'h208, 32'h208, 32'h600, 1'b0, 1'b0);
    lookup(32'h208);
    checkOutput("nt_miss_flag", {30'd0, lastFlag}, 32'd0);

    update(32'h20C, 32'h20C, 32'h400, 1'b1, 1'b1);
    update(32'h20C, 32'h20C, 32'h400, 1'b0, 1'b0);
    lookup(32'h20C);
    checkOutput("uncond_flag", {30'd0, lastFlag}, 32'd3);
    checkOutput("uncond_target", lastTarget, 32'h400);

    applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 32'h700, 1'b1, 1'b0);
    lookup(32'h100);
    checkOutput("rst_prio_flag", {30'd0, lastFlag}, 32'd0);
    lookup(32'h20C);
    checkOutput("rst_clear_flag", {30'd0, lastFlag}, 32'd0);
    lookup(32'hFFFF_FFFC);
    checkOutput("wrap_target", lastTarget, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] pool [8];
      logic [31:0] pc;
      logic [31:0] upc;
      pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h104; pool[3] = 32'h3C0;
      pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h1000_0108; pool[6] = 32'h0; pool[7] = 32'h13E;
      pc  = pool[$urandom_range(0, 7)];
      upc = pool[$urandom_range(0, 7)];
      applyStimulus(($urandom_range(0, 49) == 0), pc, 1'($urandom_range(0, 1)), upc,
                    {$urandom, 2'b00} >> 2 << 2, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 4, SHALL set the log2 of the number of direct-mapped entries (16 entries at default).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-004 Port if_pc, input, 32 bits, SHALL carry the current fetch PC to be looked up.
REQ-005 Port pred_target, output, 32 bits, SHALL carry the predicted next PC for if_pc.
REQ-006 Port btb_flag, output, 2 bits, SHALL carry {hit, pred_taken} for capture into the IF/ID register.
REQ-007 Port upd_valid, input, 1 bit, SHALL qualify a resolved control-transfer update from EX.
REQ-008 Port upd_pc, input, 32 bits, SHALL carry the PC of the resolved instruction.
REQ-009 Port upd_target, input, 32 bits, SHALL carry the resolved taken target.
REQ-010 Port upd_taken, input, 1 bit, SHALL indicate that the resolved instruction was taken.
REQ-011 Port upd_uncond, input, 1 bit, SHALL indicate jal/jalr; it is used only when upd_taken=1.

Function
REQ-012 Each entry SHALL hold: valid (1 bit), tag (30-INDEX_BITS bits), target (32 bits), and a 2-bit saturating counter.
REQ-013 Index SHALL be pc[INDEX_BITS+1:2] and tag SHALL be pc[31:INDEX_BITS+2]; pc[1:0] SHALL be ignored.
REQ-014 Lookup SHALL be combinational (0-cycle latency): hit = valid && (tag match) for the if_pc entry.
REQ-015 pred_taken SHALL be hit && counter[1].
REQ-016 pred_target SHALL be the stored target when pred_taken=1, else if_pc+4 (modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000).
REQ-017 The update SHALL be applied at the clock edge while upd_valid=1, and at no other time.
REQ-018 Update, miss, upd_taken=1: the block SHALL allocate/replace the entry with valid=1, the new tag and target, and counter = 2'b11 if upd_uncond else 2'b10.
REQ-019 Update, miss, upd_taken=0: the block SHALL leave the table unchanged (no allocation).
REQ-020 Update, hit, upd_taken=1: the block SHALL increment the counter, saturating at 2'b11, and overwrite the target with upd_target.
REQ-021 Update, hit, upd_taken=0: the block SHALL decrement the counter, saturating at 2'b00; target and valid are unchanged.
REQ-022 Simultaneous lookup and update to the same index SHALL return pre-update contents; new contents become visible the next cycle.
REQ-023 An update SHALL modify only the indexed entry; all other entries are unchanged.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL clear every valid bit and set every counter to 2'b01; tag and target contents are don't-care.
REQ-025 rst SHALL take priority over a concurrent upd_valid; that update is dropped.
REQ-026 During and after reset, until the first allocation, outputs SHALL be btb_flag=2'b00 and pred_target=if_pc+4.

Verification
REQ-027 Reset, then if_pc=0x00000100 -> btb_flag=2'b00, pred_target=0x00000104.
REQ-028 Update upd_pc=0x100, upd_target=0x200, upd_taken=1, upd_uncond=0; next cycle if_pc=0x100 -> btb_flag=2'b11, pred_target=0x200.
REQ-029 After REQ-028, apply two not-taken updates to 0x100 (counter 10->01->00) -> btb_flag=2'b10, pred_target=0x104; one taken update (counter 01) -> still 2'b10; a second taken update -> 2'b11.
REQ-030 Allocate 0x100 with INDEX_BITS=4, then allocate 0x140 (same index, different tag) taken to 0x300 -> if_pc=0x100 gives btb_flag=2'b00, and if_pc=0x140 gives 2'b11 with target 0x300.
REQ-031 Same-cycle lookup and update at if_pc=upd_pc=0x180 (miss, taken) -> that cycle btb_flag=2'b00; the following cycle btb_flag=2'b11.
REQ-032 rst=1 and a taken update to 0x100 in the same cycle -> next cycle lookup of 0x100 gives btb_flag=2'b00; also if_pc=0xFFFFFFFC on a miss -> pred_target=0x00000000.
